// File: rtl/alu_rs_if.sv
// Bundle of issue, result-broadcast and dispatch signals around the ALU reservation station.
// master: issue stage / broadcast sources / ALU side.  slave: the reservation station.
interface alu_rs_if #(
    parameter int unsigned ROB_POS_W = 4
);
    logic                 issue_en;
    logic [6:0]           issue_opcode;
    logic [2:0]           issue_func3;
    logic                 issue_func1;
    logic                 issue_rs1_pend;
    logic [31:0]          issue_rs1_val;
    logic [ROB_POS_W-1:0] issue_rs1_dep;
    logic                 issue_rs2_pend;
    logic [31:0]          issue_rs2_val;
    logic [ROB_POS_W-1:0] issue_rs2_dep;
    logic [31:0]          issue_imm;
    logic [31:0]          issue_pc;
    logic [ROB_POS_W-1:0] issue_rob_pos;

    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [31:0]          alu_result_val;
    logic                 lsb_result;
    logic [ROB_POS_W-1:0] lsb_result_rob_pos;
    logic [31:0]          lsb_result_val;

    logic                 full;
    logic                 alu_en;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_func3;
    logic                 alu_func1;
    logic [31:0]          alu_val1;
    logic [31:0]          alu_val2;
    logic [31:0]          alu_imm;
    logic [31:0]          alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;

    modport master (
        output issue_en, issue_opcode, issue_func3, issue_func1,
               issue_rs1_pend, issue_rs1_val, issue_rs1_dep,
               issue_rs2_pend, issue_rs2_val, issue_rs2_dep,
               issue_imm, issue_pc, issue_rob_pos,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  full, alu_en, alu_opcode, alu_func3, alu_func1,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

    modport slave (
        input  issue_en, issue_opcode, issue_func3, issue_func1,
               issue_rs1_pend, issue_rs1_val, issue_rs1_dep,
               issue_rs2_pend, issue_rs2_val, issue_rs2_dep,
               issue_imm, issue_pc, issue_rob_pos,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        output full, alu_en, alu_opcode, alu_func3, alu_func1,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ALU/branch instructions, snoops the ALU and
// LSB result broadcasts for missing operands, and dispatches the lowest-index ready
// entry to the ALU as a registered one-cycle pulse.
module alu_rs #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned RS_IDX_W  = 4,
    parameter int unsigned ROB_POS_W = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    rollback,
    alu_rs_if.slave bus
);
    typedef struct packed {
        logic                 busy;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func1;
        logic                 pend1;
        logic [ROB_POS_W-1:0] dep1;
        logic [31:0]          val1;
        logic                 pend2;
        logic [ROB_POS_W-1:0] dep2;
        logic [31:0]          val2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } entry_t;

    typedef struct packed {
        logic                 en;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func1;
        logic [31:0]          val1;
        logic [31:0]          val2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } disp_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    disp_t  out_q;
    disp_t  out_d;

    logic [RS_SIZE-1:0]  busy_vec;
    logic                sel_found;
    logic [RS_IDX_W-1:0] sel_idx;
    logic                free_found;
    logic [RS_IDX_W-1:0] free_idx;

    // Returns {pend, val} after checking one operand against both broadcasts; ALU port wins.
    function automatic logic [32:0] snoop(
        input logic                 pend,
        input logic [ROB_POS_W-1:0] dep,
        input logic [31:0]          val,
        input logic                 a_v,
        input logic [ROB_POS_W-1:0] a_tag,
        input logic [31:0]          a_val,
        input logic                 l_v,
        input logic [ROB_POS_W-1:0] l_tag,
        input logic [31:0]          l_val
    );
        logic [32:0] r;
        r = {pend, val};
        if (pend && a_v && dep == a_tag) begin
            r = {1'b0, a_val};
        end else if (pend && l_v && dep == l_tag) begin
            r = {1'b0, l_val};
        end
        return r;
    endfunction

    // Lowest-index ready entry for dispatch and lowest-index free entry for issue.
    always_comb begin
        busy_vec   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = ent_q[i].busy;
            if (!sel_found && ent_q[i].busy && !ent_q[i].pend1 && !ent_q[i].pend2) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
            end
            if (!free_found && !ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
        end
    end

    assign bus.full = &busy_vec;

    // Next state: wake-up of waiting operands, dispatch of the selected entry, issue with bypass.
    always_comb begin
        ent_d     = ent_q;
        out_d     = out_q;
        out_d.en  = 1'b0;

        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
                {ent_d[i].pend1, ent_d[i].val1} = snoop(ent_q[i].pend1, ent_q[i].dep1, ent_q[i].val1,
                    bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                    bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
                {ent_d[i].pend2, ent_d[i].val2} = snoop(ent_q[i].pend2, ent_q[i].dep2, ent_q[i].val2,
                    bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                    bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
            end
        end

        if (sel_found) begin
            out_d.en             = 1'b1;
            out_d.opcode         = ent_q[sel_idx].opcode;
            out_d.func3          = ent_q[sel_idx].func3;
            out_d.func1          = ent_q[sel_idx].func1;
            out_d.val1           = ent_q[sel_idx].val1;
            out_d.val2           = ent_q[sel_idx].val2;
            out_d.imm            = ent_q[sel_idx].imm;
            out_d.pc             = ent_q[sel_idx].pc;
            out_d.rob_pos        = ent_q[sel_idx].rob_pos;
            ent_d[sel_idx].busy  = 1'b0;
        end

        // The free slot is never the dispatched one, so issue and dispatch never collide.
        if (bus.issue_en && free_found) begin
            ent_d[free_idx].busy    = 1'b1;
            ent_d[free_idx].opcode  = bus.issue_opcode;
            ent_d[free_idx].func3   = bus.issue_func3;
            ent_d[free_idx].func1   = bus.issue_func1;
            ent_d[free_idx].dep1    = bus.issue_rs1_dep;
            ent_d[free_idx].dep2    = bus.issue_rs2_dep;
            ent_d[free_idx].imm     = bus.issue_imm;
            ent_d[free_idx].pc      = bus.issue_pc;
            ent_d[free_idx].rob_pos = bus.issue_rob_pos;
            {ent_d[free_idx].pend1, ent_d[free_idx].val1} = snoop(bus.issue_rs1_pend, bus.issue_rs1_dep,
                bus.issue_rs1_val,
                bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
            {ent_d[free_idx].pend2, ent_d[free_idx].val2} = snoop(bus.issue_rs2_pend, bus.issue_rs2_dep,
                bus.issue_rs2_val,
                bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        end
    end

    // State update: reset/rollback clear everything, rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            out_q <= '0;
        end else if (rdy) begin
            ent_q <= ent_d;
            out_q <= out_d;
        end
    end

    assign bus.alu_en      = out_q.en;
    assign bus.alu_opcode  = out_q.opcode;
    assign bus.alu_func3   = out_q.func3;
    assign bus.alu_func1   = out_q.func1;
    assign bus.alu_val1    = out_q.val1;
    assign bus.alu_val2    = out_q.val2;
    assign bus.alu_imm     = out_q.imm;
    assign bus.alu_pc      = out_q.pc;
    assign bus.alu_rob_pos = out_q.rob_pos;
endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus random traffic, checked by a scoreboard
// fed from a behavioural model of the station.
module tb_alu_rs;
    localparam int unsigned RS_SIZE   = 16;
    localparam int unsigned RS_IDX_W  = 4;
    localparam int unsigned ROB_POS_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    always #5 clk = ~clk;

    alu_rs_if #(.ROB_POS_W(ROB_POS_W)) bus ();

    alu_rs #(.RS_SIZE(RS_SIZE), .RS_IDX_W(RS_IDX_W), .ROB_POS_W(ROB_POS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        int          stamp;
    } disp_t;

    typedef struct {
        bit          busy;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f1;
        bit          p1;
        logic [3:0]  d1;
        logic [31:0] v1;
        bit          p2;
        logic [3:0]  d2;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } ment_t;

    disp_t exp_q[$];
    ment_t m[RS_SIZE];
    bit    m_en;
    disp_t m_last;
    int    errors = 0;
    int    checks = 0;
    int    ecount = 0;
    bit    edge_live = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // An operand waiting on a tag takes the value of a matching broadcast; ALU first.
    function automatic void wake(inout bit p, input logic [3:0] d, inout logic [31:0] v);
        if (!p) return;
        if (bus.alu_result && bus.alu_result_rob_pos == d) begin
            v = bus.alu_result_val; p = 1'b0;
        end else if (bus.lsb_result && bus.lsb_result_rob_pos == d) begin
            v = bus.lsb_result_val; p = 1'b0;
        end
    endfunction

    // What the station does at the coming clock edge, given the inputs currently driven.
    task automatic model_step();
        int sel = -1;
        int free = -1;
        bit p;
        logic [31:0] v;
        disp_t d;
        if (rst || rollback) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            m_en = 1'b0;
            m_last = '{default: 0};
            return;
        end
        if (!rdy) return;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
            if (free < 0 && !m[i].busy) free = i;
        end
        m_en = (sel >= 0);
        if (sel >= 0) begin
            d = '{op: m[sel].op, f3: m[sel].f3, f1: m[sel].f1, v1: m[sel].v1, v2: m[sel].v2,
                  imm: m[sel].imm, pc: m[sel].pc, rob: m[sel].rob, stamp: ecount + 1};
            exp_q.push_back(d);
            m_last = d;
            m[sel].busy = 1'b0;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m[i].busy) begin
                p = m[i].p1; v = m[i].v1; wake(p, m[i].d1, v); m[i].p1 = p; m[i].v1 = v;
                p = m[i].p2; v = m[i].v2; wake(p, m[i].d2, v); m[i].p2 = p; m[i].v2 = v;
            end
        end
        if (bus.issue_en && free >= 0) begin
            m[free] = '{busy: 1'b1, op: bus.issue_opcode, f3: bus.issue_func3, f1: bus.issue_func1,
                        p1: bus.issue_rs1_pend, d1: bus.issue_rs1_dep, v1: bus.issue_rs1_val,
                        p2: bus.issue_rs2_pend, d2: bus.issue_rs2_dep, v2: bus.issue_rs2_val,
                        imm: bus.issue_imm, pc: bus.issue_pc, rob: bus.issue_rob_pos};
            p = m[free].p1; v = m[free].v1; wake(p, m[free].d1, v); m[free].p1 = p; m[free].v1 = v;
            p = m[free].p2; v = m[free].v2; wake(p, m[free].d2, v); m[free].p2 = p; m[free].v2 = v;
        end
    endtask

    task automatic clear_inputs();
        bus.issue_en = 1'b0; bus.issue_opcode = '0; bus.issue_func3 = '0; bus.issue_func1 = 1'b0;
        bus.issue_rs1_pend = 1'b0; bus.issue_rs1_val = '0; bus.issue_rs1_dep = '0;
        bus.issue_rs2_pend = 1'b0; bus.issue_rs2_val = '0; bus.issue_rs2_dep = '0;
        bus.issue_imm = '0; bus.issue_pc = '0; bus.issue_rob_pos = '0;
        bus.alu_result = 1'b0; bus.alu_result_rob_pos = '0; bus.alu_result_val = '0;
        bus.lsb_result = 1'b0; bus.lsb_result_rob_pos = '0; bus.lsb_result_val = '0;
        rollback = 1'b0;
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                             input bit p1, input logic [3:0] d1, input logic [31:0] v1,
                             input bit p2, input logic [3:0] d2, input logic [31:0] v2,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        bus.issue_en = 1'b1; bus.issue_opcode = op; bus.issue_func3 = f3; bus.issue_func1 = f1;
        bus.issue_rs1_pend = p1; bus.issue_rs1_dep = d1; bus.issue_rs1_val = v1;
        bus.issue_rs2_pend = p2; bus.issue_rs2_dep = d2; bus.issue_rs2_val = v2;
        bus.issue_imm = imm; bus.issue_pc = pc; bus.issue_rob_pos = rob;
    endtask

    // One clock: check full, advance the model, take the edge, return at the next negedge.
    task automatic tick();
        check("full", bus.full, m_full());
        edge_live = rdy && !rst && !rollback;
        model_step();
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    // Monitor: every live edge consumes exactly the dispatch the model predicted for it.
    initial begin : monitor
        bit    live;
        disp_t e;
        forever begin
            @(posedge clk);
            live = edge_live;
            #1;
            if (live) begin
                if (bus.alu_en) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_dispatch: got alu_en=1 rob_pos=%0d, expected no dispatch",
                                 bus.alu_rob_pos);
                    end else begin
                        e = exp_q.pop_front();
                        check("dispatch_edge", ecount, e.stamp);
                        check("dispatch_ctl", {bus.alu_opcode, bus.alu_func3, bus.alu_func1, bus.alu_rob_pos},
                              {e.op, e.f3, e.f1, e.rob});
                        check("dispatch_ops", {bus.alu_val1, bus.alu_val2, bus.alu_imm, bus.alu_pc},
                              {e.v1, e.v2, e.imm, e.pc});
                    end
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL missing_dispatch: got alu_en=0 expected dispatch of rob_pos=%0d", e.rob);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; rdy = 1'b1;
        clear_inputs();
        for (int i = 0; i < RS_SIZE; i++) m[i] = '{default: 0};
        m_en = 1'b0; m_last = '{default: 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_full", bus.full, 0);
        check("reset_alu_en", bus.alu_en, 0);
        check("reset_data", {bus.alu_val1, bus.alu_val2, bus.alu_imm, bus.alu_pc}, 0);

        // Idle after reset.
        repeat (10) tick();
        check("idle_alu_en", bus.alu_en, 0);

        // Ready ADDI: dispatched one edge after issue, pulse lasts one cycle.
        set_issue(7'b0010011, 3'd0, 1'b0, 0, 4'd0, 32'd5, 0, 4'd0, 32'd0, 32'd3, 32'h100, 4'd2);
        tick();
        clear_inputs();
        tick();
        check("addi_en", bus.alu_en, 1);
        check("addi_vals", {bus.alu_val1, bus.alu_imm, 28'd0, bus.alu_rob_pos}, {32'd5, 32'd3, 28'd0, 4'd2});
        tick();
        check("addi_pulse_off", bus.alu_en, 0);

        // Wake-up from the LSB port.
        set_issue(7'b0110011, 3'd0, 1'b0, 1, 4'd7, 32'd0, 0, 4'd0, 32'd1, 32'd0, 32'h104, 4'd5);
        tick();
        clear_inputs();
        repeat (3) tick();
        bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = 4'd7; bus.lsb_result_val = 32'h10;
        tick();
        clear_inputs();
        tick();
        check("wake_en", bus.alu_en, 1);
        check("wake_vals", {bus.alu_val1, bus.alu_val2}, {32'h10, 32'd1});

        // Issue bypass from the ALU port.
        set_issue(7'b0110011, 3'd1, 1'b0, 0, 4'd0, 32'd9, 1, 4'd4, 32'd0, 32'd0, 32'h108, 4'd6);
        bus.alu_result = 1'b1; bus.alu_result_rob_pos = 4'd4; bus.alu_result_val = 32'hAB;
        tick();
        clear_inputs();
        tick();
        check("bypass_en", bus.alu_en, 1);
        check("bypass_val2", bus.alu_val2, 32'hAB);

        // Fill all entries, try a 17th issue, then wake two and check selection order.
        for (int i = 0; i < RS_SIZE; i++) begin
            set_issue(7'b1100011, 3'(i), 1'b0, 1, 4'((i + 1) % RS_SIZE), 32'd0, 0, 4'd0, 32'(i * 3),
                      32'(i), 32'(i * 4), 4'(i));
            tick();
        end
        clear_inputs();
        check("full_set", bus.full, 1);
        set_issue(7'b0110111, 3'd7, 1'b1, 1, 4'd5, 32'd0, 0, 4'd0, 32'hDEAD, 32'hBEEF, 32'hDEAD, 4'hE);
        tick();
        clear_inputs();
        bus.alu_result = 1'b1; bus.alu_result_rob_pos = 4'd3; bus.alu_result_val = 32'h33;
        bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = 4'd9; bus.lsb_result_val = 32'h99;
        tick();
        clear_inputs();
        tick();
        check("select_first", {bus.alu_en, bus.alu_rob_pos, bus.alu_val1}, {1'b1, 4'd2, 32'h33});
        tick();
        check("select_second", {bus.alu_en, bus.alu_rob_pos, bus.alu_val1}, {1'b1, 4'd8, 32'h99});
        for (int t = 0; t < RS_SIZE; t++) begin
            bus.alu_result = 1'b1; bus.alu_result_rob_pos = 4'(t); bus.alu_result_val = 32'(t + 32'h100);
            tick();
        end
        clear_inputs();
        repeat (20) tick();

        // Rollback flushes busy entries; their later wake-ups must dispatch nothing.
        for (int i = 0; i < 4; i++) begin
            set_issue(7'b0110011, 3'd0, 1'b0, 1, 4'(i + 1), 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 4'(i + 8));
            tick();
        end
        clear_inputs();
        rollback = 1'b1;
        tick();
        clear_inputs();
        check("rollback_full", bus.full, 0);
        check("rollback_out", {bus.alu_en, bus.alu_val1, bus.alu_rob_pos}, 0);
        for (int t = 1; t <= 4; t++) begin
            bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = 4'(t); bus.lsb_result_val = 32'(t);
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        // rdy low: a ready entry waits, alu_en holds its high value, issues are dropped.
        set_issue(7'b0010011, 3'd2, 1'b0, 0, 4'd0, 32'h11, 0, 4'd0, 32'd0, 32'd1, 32'h200, 4'd10);
        tick();
        set_issue(7'b0010011, 3'd3, 1'b1, 0, 4'd0, 32'h22, 0, 4'd0, 32'd0, 32'd2, 32'h204, 4'd11);
        tick();
        clear_inputs();
        rdy = 1'b0;
        set_issue(7'b0010011, 3'd4, 1'b0, 0, 4'd0, 32'h33, 0, 4'd0, 32'd0, 32'd3, 32'h208, 4'd12);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_hold", {bus.alu_en, bus.alu_rob_pos, bus.alu_val1},
                  {m_en, m_last.rob, m_last.v1});
        end
        clear_inputs();
        rdy = 1'b1;
        tick();
        check("stall_release", {bus.alu_en, bus.alu_rob_pos}, {1'b1, 4'd11});
        repeat (3) tick();

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            clear_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 59) == 0);
            if (!m_full() && $urandom_range(0, 1) == 1)
                set_issue(7'($urandom), 3'($urandom), 1'($urandom),
                          ($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
                          ($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
                          $urandom, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                bus.alu_result = 1'b1; bus.alu_result_rob_pos = 4'($urandom); bus.alu_result_val = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = 4'($urandom); bus.lsb_result_val = $urandom;
            end
            tick();
        end

        // Drain: broadcast every tag until all waiting operands have been satisfied.
        clear_inputs();
        rdy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < RS_SIZE; t++) begin
                bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = 4'(t); bus.lsb_result_val = $urandom;
                tick();
            end
        end
        clear_inputs();
        repeat (20) tick();
        check("drained_full", bus.full, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
